// File: rtl/npu_gemm_array.sv
// npu_gemm_array: N x N output-stationary systolic engine computing C = A*B from internal A/B operand banks.
// Latency: start accepted at edge E0, done pulses after edge E0+3N+1; rd_data is valid one edge after rd_addr.
// Backpressure: none; starts while busy are dropped, writes while busy or out of range are dropped and set err.
// Build option: define NPU_GEMM_RELU_EN to clamp negative results to zero on writeback.
module npu_gemm_array #(
  parameter int N     = 3,
  parameter int DW    = 32,
  parameter int ACC_W = 2*DW+4,
  parameter int AW    = $clog2(2*N*N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [DW-1:0]    wr_data,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic [AW-1:0]    rd_addr,
  output logic [ACC_W-1:0] rd_data
);

  localparam int NN    = N*N;
  localparam int IW    = $clog2(NN);
  localparam int KW    = $clog2(3*N);
  localparam int KLAST = 3*N-2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPUTE,
    S_WRITEBACK,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_accept;

  logic [KW-1:0]    r_k;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [ACC_W-1:0] r_rd_data;

  // Operand banks (not reset: contents survive a reset) and result bank.
  logic [DW-1:0]    r_a_bank [NN];
  logic [DW-1:0]    r_b_bank [NN];
  logic [ACC_W-1:0] r_c_bank [NN];

  // Skewed edge feeds and the registered streams entering column 0 / row 0.
  logic signed [DW-1:0] w_a_feed [N];
  logic signed [DW-1:0] w_b_feed [N];
  logic signed [DW-1:0] r_a_in   [N];
  logic signed [DW-1:0] r_b_in   [N];

  // PE outputs: east-bound A, south-bound B, and the stationary accumulators.
  logic signed [DW-1:0] w_a_pe [N][N];
  logic signed [DW-1:0] w_b_pe [N][N];
  logic [ACC_W-1:0]     w_acc  [N][N];

  logic          w_wr_in_range;
  logic          w_wr_legal;
  logic          w_wr_illegal;
  logic          w_wr_is_a;
  logic [IW-1:0] w_wr_a_idx;
  logic [IW-1:0] w_wr_b_idx;
  logic          w_rd_hit;

  assign busy    = r_busy;
  assign done    = r_done;
  assign err     = r_err;
  assign rd_data = r_rd_data;

  // Writeback transform: raw accumulator, or clamped at zero in the ReLU build.
  function automatic logic [ACC_W-1:0] f_wb(input logic [ACC_W-1:0] v);
`ifdef NPU_GEMM_RELU_EN
    f_wb = v[ACC_W-1] ? '0 : v;
`else
    f_wb = v;
`endif
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; start is only honoured from IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        if (r_k == KW'(KLAST)) begin
          w_state_nxt = S_WRITEBACK;
        end
      end
      S_WRITEBACK: w_state_nxt = S_DONE;
      S_DONE:      w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // Step counter k runs 0..3N-2 through COMPUTE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_k <= '0;
    end else if (w_accept) begin
      r_k <= '0;
    end else if (r_state == S_COMPUTE) begin
      r_k <= r_k + KW'(1);
    end
  end

  // Status flags are registered so done lands one edge after the DONE state and busy drops on that same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      r_done <= (r_state == S_DONE);
      if (w_wr_illegal) begin
        r_err <= 1'b1;
      end else if (w_accept) begin
        r_err <= 1'b0;
      end
    end
  end

  // Write decode: only IDLE writes to a valid address land; everything else flags err.
  always_comb begin
    w_wr_in_range = (32'(wr_addr) < 32'(2*NN));
    w_wr_is_a     = (32'(wr_addr) < 32'(NN));
    w_wr_legal    = wr_en && (r_state == S_IDLE) && w_wr_in_range;
    w_wr_illegal  = wr_en && !((r_state == S_IDLE) && w_wr_in_range);
    w_wr_a_idx    = wr_addr[IW-1:0];
    w_wr_b_idx    = IW'(wr_addr - AW'(NN));
  end

  // Operand bank write, committed on the edge; no reset so operands are retained.
  always_ff @(posedge clk) begin
    if (w_wr_legal) begin
      if (w_wr_is_a) begin
        r_a_bank[w_wr_a_idx] <= wr_data;
      end else begin
        r_b_bank[w_wr_b_idx] <= wr_data;
      end
    end
  end

  // Skewed feeds: row i sees A[i][k-i], column j sees B[k-j][j], zero outside the window.
  for (genvar gi = 0; gi < N; gi++) begin : g_feed
    always_comb begin
      w_a_feed[gi] = '0;
      w_b_feed[gi] = '0;
      if ((r_state == S_COMPUTE) && (32'(r_k) >= 32'(gi)) && (32'(r_k) < 32'(gi + N))) begin
        w_a_feed[gi] = r_a_bank[IW'(gi*N) + (IW'(r_k) - IW'(gi))];
        w_b_feed[gi] = r_b_bank[(IW'(r_k) - IW'(gi)) * IW'(N) + IW'(gi)];
      end
    end
  end

  // Edge feed registers; zero outside COMPUTE so the array starts each run from empty streams.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        r_a_in[i] <= '0;
        r_b_in[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        r_a_in[i] <= w_a_feed[i];
        r_b_in[i] <= w_b_feed[i];
      end
    end
  end

  // MAC grid: each PE accumulates a*b and forwards a east and b south.
  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      logic signed [DW-1:0]   w_a;
      logic signed [DW-1:0]   w_b;
      logic signed [2*DW-1:0] w_prod;
      logic [ACC_W-1:0]       w_prod_ext;
      logic signed [DW-1:0]   r_a_q;
      logic signed [DW-1:0]   r_b_q;
      logic [ACC_W-1:0]       r_acc;

      if (gj == 0) begin : g_asrc
        assign w_a = r_a_in[gi];
      end else begin : g_asrc
        assign w_a = w_a_pe[gi][gj-1];
      end

      if (gi == 0) begin : g_bsrc
        assign w_b = r_b_in[gj];
      end else begin : g_bsrc
        assign w_b = w_b_pe[gi-1][gj];
      end

      assign w_prod     = w_a * w_b;
      assign w_prod_ext = {{(ACC_W-2*DW){w_prod[2*DW-1]}}, w_prod};

      // Accumulate during COMPUTE; a new run clears the PE before its first product.
      always_ff @(posedge clk) begin
        if (!rst) begin
          r_a_q <= '0;
          r_b_q <= '0;
          r_acc <= '0;
        end else if (w_accept) begin
          r_a_q <= '0;
          r_b_q <= '0;
          r_acc <= '0;
        end else if (r_state == S_COMPUTE) begin
          r_a_q <= w_a;
          r_b_q <= w_b;
          r_acc <= r_acc + w_prod_ext;
        end
      end

      assign w_a_pe[gi][gj] = r_a_q;
      assign w_b_pe[gi][gj] = r_b_q;
      assign w_acc[gi][gj]  = r_acc;
    end
  end

  // Result bank: captured in WRITEBACK, otherwise holds the previous C.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NN; i++) begin
        r_c_bank[i] <= '0;
      end
    end else if (r_state == S_WRITEBACK) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          r_c_bank[i*N+j] <= f_wb(w_acc[i][j]);
        end
      end
    end
  end

  assign w_rd_hit = (32'(rd_addr) < 32'(NN));

  // Registered read port; out-of-range indices read as zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= w_rd_hit ? r_c_bank[rd_addr[IW-1:0]] : '0;
    end
  end

endmodule

// File: tb/tb_npu_gemm_array.sv
// Bench for npu_gemm_array at N=3: directed and random operand sets checked against a plain matrix-product model.
// Also covers handshake timing, illegal writes, mid-run reset and out-of-range addressing.
`timescale 1ns/1ps
module tb_npu_gemm_array;

  localparam int N     = 3;
  localparam int DW    = 32;
  localparam int ACC_W = 2*DW+4;
  localparam int AW    = $clog2(2*N*N);
  localparam int NN    = N*N;
  localparam int LAT   = 3*N+1;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic             start;
  logic             busy;
  logic             done;
  logic             err;
  logic [AW-1:0]    rd_addr;
  logic [ACC_W-1:0] rd_data;

  always #5 clk = ~clk;

  npu_gemm_array #(.N(N), .DW(DW), .ACC_W(ACC_W), .AW(AW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .busy(busy), .done(done), .err(err),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  int n_chk = 0;
  int n_err = 0;

  logic signed [DW-1:0] ma [NN];
  logic signed [DW-1:0] mb [NN];
  logic [ACC_W-1:0]     mc [NN];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [ACC_W-1:0] obs, input logic [ACC_W-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: C = A*B as a straight triple loop in ACC_W-bit signed arithmetic.
  function automatic void model();
    logic signed [ACC_W-1:0] s;
    logic signed [ACC_W-1:0] x;
    logic signed [ACC_W-1:0] y;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        s = '0;
        for (int m = 0; m < N; m++) begin
          x = ma[i*N+m];
          y = mb[m*N+j];
          s = s + x * y;
        end
`ifdef NPU_GEMM_RELU_EN
        if (s < 0) s = '0;
`endif
        mc[i*N+j] = s;
      end
    end
  endfunction

  task automatic load_ab();
    for (int idx = 0; idx < 2*NN; idx++) begin
      wr_en   = 1'b1;
      wr_addr = AW'(idx);
      wr_data = (idx < NN) ? ma[idx] : mb[idx-NN];
      tick();
    end
    wr_en = 1'b0;
  endtask

  // Called just after the accepting edge; counts edges until done and busy samples before it.
  task automatic wait_done(output int cnt, output int bsy);
    cnt = 0;
    bsy = (busy === 1'b1) ? 1 : 0;
    while (cnt < 40) begin
      tick();
      cnt++;
      if (done === 1'b1) break;
      if (busy === 1'b1) bsy++;
    end
  endtask

  task automatic read_c(input string tag);
    for (int idx = 0; idx < NN; idx++) begin
      rd_addr = AW'(idx);
      tick();
      check({tag, "_c", $sformatf("%0d", idx)}, rd_data, mc[idx]);
    end
    rd_addr = AW'(NN);
    tick();
    check({tag, "_rd_oob"}, rd_data, '0);
    rd_addr = '0;
  endtask

  task automatic run(input string tag);
    int cnt;
    int bsy;
    rd_addr = '0;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    check({tag, "_busy_accept"}, busy, 1);
    check({tag, "_err_accept"}, err, 0);
    wait_done(cnt, bsy);
    check({tag, "_done_edge"}, cnt, LAT);
    check({tag, "_busy_cycles"}, bsy, LAT);
    check({tag, "_c0_at_done"}, rd_data, mc[0]);
    tick();
    check({tag, "_done_pulse"}, done, 0);
    read_c(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int bsy;
    int ndone;

    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; rd_addr = '0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_rd", rd_data, '0);
    rst = 1'b1;
    tick();

    // Identity times 1..9.
    for (int i = 0; i < NN; i++) begin
      ma[i] = ((i % N) == (i / N)) ? 1 : 0;
      mb[i] = i + 1;
    end
    model(); load_ab(); run("ident");
    check("ident_err", err, 0);

    // Constant matrices with a negative result.
    for (int i = 0; i < NN; i++) begin
      ma[i] = 2;
      mb[i] = -3;
    end
    model(); load_ab(); run("const");
    check("const_err", err, 0);

    // Full-width random operands, then small signed ones.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NN; i++) begin
        if (r < 2) begin
          ma[i] = $urandom;
          mb[i] = $urandom;
        end else begin
          ma[i] = DW'(int'($urandom_range(0, 200)) - 100);
          mb[i] = DW'(int'($urandom_range(0, 200)) - 100);
        end
      end
      model(); load_ab(); run($sformatf("rnd%0d", r));
    end

    // Back-to-back: start asserted in the done cycle is accepted on the next edge.
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(cnt, bsy);
    check("b2b_first_done", cnt, LAT);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b_accept", busy, 1);
    wait_done(cnt, bsy);
    check("b2b_second_done", cnt, LAT);
    read_c("b2b");

    // Write and start while busy (k=2): both dropped, err sticks until the next accepted start.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    wr_en = 1'b1; wr_addr = '0; wr_data = ma[0] + 5; start = 1'b1;
    tick();
    wr_en = 1'b0; start = 1'b0;
    check("busy_wr_err", err, 1);
    wait_done(cnt, bsy);
    check("busy_wr_done", cnt, LAT - 3);
    check("busy_wr_err_sticky", err, 1);
    repeat (3) tick();
    check("busy_start_ignored", busy, 0);
    read_c("busy_wr");
    run("err_clear");

    // Reset at k=4: run aborted, C cleared, operands retained.
    for (int i = 0; i < NN; i++) begin
      ma[i] = DW'(int'($urandom_range(0, 2000)) - 1000);
      mb[i] = DW'(int'($urandom_range(0, 2000)) - 1000);
    end
    model(); load_ab();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_err", err, 0);
    check("midrst_rd", rd_data, '0);
    ndone = 0;
    for (int c = 0; c < LAT + 5; c++) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    check("midrst_no_done", ndone, 0);
    for (int idx = 0; idx < NN; idx++) begin
      rd_addr = AW'(idx);
      tick();
      check($sformatf("midrst_c%0d_zero", idx), rd_data, '0);
    end
    run("after_rst");

    // Out-of-range write in IDLE: flagged and dropped.
    wr_en = 1'b1; wr_addr = AW'(2*NN); wr_data = 32'h1234_5678;
    tick();
    wr_en = 1'b0;
    check("oob_wr_err", err, 1);
    wr_en = 1'b1; wr_addr = '1; wr_data = 32'h0bad_0bad;
    tick();
    wr_en = 1'b0;
    check("oob_wr_err_max", err, 1);
    run("oob_wr");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/npu_gemm_array.md
# npu_gemm_array

Parametrised N×N output-stationary systolic matrix-multiply engine; successor to the fixed 3×3 NPU. It holds operand matrices A and B in internal register banks loaded over a simple write port and computes C = A·B with a start/busy/done handshake. It drives an internal N×N MAC grid with skewed operand streams and exposes C through a registered read port. It sits beside the CPU datapath as a memory-mapped accelerator.

## Interface
- N, 3: array dimension; supported range 2..8.
- DW, 32: signed operand width.
- ACC_W, 2*DW+4: signed accumulator/result width; must be ≥ 2*DW+clog2(N).
- AW, clog2(2*N*N): address width for both ports.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset.
- wr_en  in  1  operand write strobe.
- wr_addr  in  AW  0..N*N-1 is A row-major; N*N..2*N*N-1 is B row-major.
- wr_data  in  DW  operand value.
- start  in  1  level-sampled request to begin a multiply.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when C is valid.
- err  out  1  sticky flag for an illegal write; cleared by reset or by an accepted start.
- rd_addr  in  AW  C index, row-major.
- rd_data  out  ACC_W  C[rd_addr], registered.

## Operation
- FSM states: IDLE → COMPUTE → WRITEBACK → DONE → IDLE.
- IDLE:
  - start=1 is accepted: clears all PE accumulators and err, clears the step counter k, and moves to COMPUTE.
  - wr_en writes the A/B bank.
- COMPUTE: lasts 3N-1 cycles, k = 0..3N-2.
  - Row input i gets A[i][k-i] when 0 ≤ k-i < N, else 0.
  - Column input j gets B[k-j][j] when 0 ≤ k-j < N, else 0.
- PE(i,j), each cycle:
  - acc += a_in*b_in, signed, full product sign-extended to ACC_W.
  - Registers a_in to the east neighbour and b_in to the south neighbour.
- WRITEBACK: one cycle; copies each PE acc to C[i*N+j].
- DONE: done=1 for one cycle, busy=0, returns to IDLE.
- Arithmetic: two's complement, no overflow detection. Accumulation wraps modulo 2^ACC_W if ACC_W is undersized.
- Illegal writes, both ignored with err set:
  - wr_en during busy; A/B stay frozen during a run.
  - wr_addr ≥ 2*N*N.
- start during busy or DONE is ignored. No queuing and no error.
- Reads:
  - Permitted at any time. During a run, rd_data returns the previous C.
  - rd_addr ≥ N*N returns 0.
- Write and start in the same IDLE cycle: the write commits and start is accepted. The run uses the new value.
- Reset (rst=0) at any point, including mid-COMPUTE:
  - FSM → IDLE; accumulators, pipeline registers and C bank → 0.
  - busy=0, done=0, err=0, rd_data=0.
  - A/B banks keep their contents.

## Timing
- Reset values: busy=0, done=0, err=0, rd_data=0.
- Start accepted at edge E0. busy=1 after E0. WRITEBACK occurs in cycle 3N after E0. done=1 in the cycle after edge E0+(3N+1). N=3: done on the 10th edge after E0.
- busy falls on the same edge done rises. A new start may be accepted in the cycle after done.
- Write port: zero-latency commit at the clock edge.
- Read port: rd_data valid one edge after rd_addr. C is readable from the edge on which done rises.
- Throughput: one N×N multiply per 3N+2 cycles with back-to-back starts, excluding operand reload.

## Configuration
- NPU_GEMM_RELU_EN defined: WRITEBACK stores max(acc,0), so negative results become 0.
- Undefined: WRITEBACK stores raw signed acc.
- Nothing else changes: ports, latency and FSM are identical in both builds.

## Test plan
- N=3, A=identity, B=1..9 row-major, start → done on edge 10 after acceptance; C reads back 1..9, busy high for exactly 10 cycles.
- N=3, A=all 2, B=all -3 → every C = -18. With NPU_GEMM_RELU_EN → every C = 0. err=0.
- N=4, A[i][j]=i+j, B=identity → C equals A. done 13 edges after start. Back-to-back second start accepted the cycle after done.
- Start, then at k=2 write A[0] and pulse start again → write ignored, err=1, second start ignored, result uses original A. Next accepted start clears err.
- Start, then drive rst=0 at k=4 for one cycle → busy=0, done never pulses, all C reads 0. Re-start gives the correct product from retained A/B.
- wr_addr=2*N*N with wr_en in IDLE → no bank change, err=1. rd_addr=N*N → rd_data=0 one cycle later.
